display_buffer_scheduler: RTL and testbench

//  Ping-pong scheduler for the two display line buffers (Buf0/Buf1). A pixel writer fills one buffer while
//  the raster side reads the other; buffers swap at each active line end. Generates raster timing
//  (pixel/line counters, HBlank/VBlank) and the RAM enables and selects for the display datapath.

---
 rtl/disp_timing_pkg.sv | 20 ++
 rtl/disp_raster_counter.sv | 55 +++++
 rtl/display_buffer_scheduler.sv | 179 +++++++++++++++++
 tb/tb_display_buffer_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/disp_timing_pkg.sv
// Shared state encoding and default raster timing for the display line-buffer scheduler.
package disp_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } disp_state_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_BLANK  = 160;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_BLANK  = 45;
  localparam int unsigned DEF_ADDR_W   = 10;

  function automatic int unsigned span_total(input int unsigned active, input int unsigned blank);
    return active + blank;
  endfunction

endpackage

// File: rtl/disp_raster_counter.sv
// Pixel/line raster counters with wrap, blanking decode and active-pixel flag.
module disp_raster_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  output logic [ADDR_W-1:0] px,
  output logic [ADDR_W-1:0] ln,
  output logic              sync_hb,
  output logic              sync_vb,
  output logic              active
);

  logic [ADDR_W-1:0] px_q, px_d;
  logic [ADDR_W-1:0] ln_q, ln_d;

  always_comb begin
    px_d = px_q;
    ln_d = ln_q;
    if (clr) begin
      px_d = '0;
      ln_d = '0;
    end else if (en) begin
      if (px_q == ADDR_W'(H_TOTAL - 1)) begin
        px_d = '0;
        ln_d = (ln_q == ADDR_W'(V_TOTAL - 1)) ? '0 : ln_q + ADDR_W'(1);
      end else begin
        px_d = px_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= '0;
      ln_q <= '0;
    end else begin
      px_q <= px_d;
      ln_q <= ln_d;
    end
  end

  assign px      = px_q;
  assign ln      = ln_q;
  assign sync_hb = (px_q >= ADDR_W'(H_ACTIVE));
  assign sync_vb = (ln_q >= ADDR_W'(V_ACTIVE));
  assign active  = !sync_hb && !sync_vb;

endmodule

// File: rtl/display_buffer_scheduler.sv
// Ping-pong scheduler for two display line buffers: writer fills one while the raster reads the other.
// Define DISP_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module display_buffer_scheduler
  import disp_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_BLANK  = DEF_V_BLANK,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              CSDisplay,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              WE0,
  output logic              WE1,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              RE0,
  output logic              RE1,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              SelBuff1,
  output logic              SelBlank,
  output logic              SyncHB,
  output logic              SyncVB,
  output logic [ADDR_W-1:0] Pxout,
  output logic [ADDR_W-1:0] Lineout,
`ifdef DISP_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_count,
`endif
  output logic              underrun
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_BLANK);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_BLANK);

  disp_state_e       state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_buf_q, wr_buf_d;
  logic              rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              line_ok_q, line_ok_d;
  logic              sel_buff1_q, sel_buff1_d;
  logic              sel_blank_q, sel_blank_d;

  logic [ADDR_W-1:0] px, ln;
  logic              sync_hb, sync_vb, active;
  logic              run_c, line_start_c, line_ok_c, rd_en_c, underrun_c, wr_ready_c, xfer_c;

  disp_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .ADDR_W   (ADDR_W)
  ) u_raster (
    .clk     (clock),
    .rst_n   (reset),
    .en      (run_c),
    .clr     (!CSDisplay),
    .px      (px),
    .ln      (ln),
    .sync_hb (sync_hb),
    .sync_vb (sync_vb),
    .active  (active)
  );

  // Next-state for FSM, buffer ownership, full flags and output-mux alignment.
  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_buf_d     = wr_buf_q;
    rd_buf_d     = rd_buf_q;
    wr_addr_d    = wr_addr_q;
    run_c        = (state_q == RUN);
    line_start_c = run_c && active && (px == '0);
    line_ok_c    = line_start_c ? full_q[rd_buf_q] : line_ok_q;
    rd_en_c      = run_c && active && line_ok_c;
    underrun_c   = line_start_c && !full_q[rd_buf_q];
    wr_ready_c   = (state_q != IDLE) && !full_q[wr_buf_q];
    xfer_c       = wr_ready_c && wr_valid;
    line_ok_d    = line_ok_c;
    sel_buff1_d  = rd_en_c && rd_buf_q;
    sel_blank_d  = !rd_en_c;

    if (xfer_c) begin
      if (wr_addr_q == ADDR_W'(H_ACTIVE - 1)) begin
        full_d[wr_buf_q] = 1'b1;
        wr_addr_d        = '0;
        wr_buf_d         = !wr_buf_q;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end

    // Writer and reader always target different buffers, so set and clear never collide.
    if (rd_en_c && (px == ADDR_W'(H_ACTIVE - 1))) begin
      full_d[rd_buf_q] = 1'b0;
      rd_buf_d         = !rd_buf_q;
    end

    case (state_q)
      IDLE:    state_d = PRIME;
      PRIME:   if (full_q[0]) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (!CSDisplay) begin
      state_d     = IDLE;
      full_d      = '0;
      wr_buf_d    = 1'b0;
      rd_buf_d    = 1'b0;
      wr_addr_d   = '0;
      line_ok_d   = 1'b0;
      sel_buff1_d = 1'b0;
      sel_blank_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      full_q      <= '0;
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      wr_addr_q   <= '0;
      line_ok_q   <= 1'b0;
      sel_buff1_q <= 1'b0;
      sel_blank_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      wr_addr_q   <= wr_addr_d;
      line_ok_q   <= line_ok_d;
      sel_buff1_q <= sel_buff1_d;
      sel_blank_q <= sel_blank_d;
    end
  end

`ifdef DISP_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q, urun_cnt_d;

  always_comb begin
    urun_cnt_d = urun_cnt_q;
    if (!CSDisplay) begin
      urun_cnt_d = '0;
    end else if (underrun_c && (urun_cnt_q != 16'hFFFF)) begin
      urun_cnt_d = urun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) urun_cnt_q <= '0;
    else        urun_cnt_q <= urun_cnt_d;
  end

  assign underrun_count = urun_cnt_q;
`endif

  assign wr_ready = wr_ready_c;
  assign WE0      = xfer_c && !wr_buf_q;
  assign WE1      = xfer_c && wr_buf_q;
  assign wr_addr  = wr_addr_q;
  assign RE0      = rd_en_c && !rd_buf_q;
  assign RE1      = rd_en_c && rd_buf_q;
  assign rd_addr  = rd_en_c ? px : '0;
  assign SelBuff1 = sel_buff1_q;
  assign SelBlank = sel_blank_q;
  assign SyncHB   = sync_hb;
  assign SyncVB   = sync_vb;
  assign Pxout    = px;
  assign Lineout  = ln;
  assign underrun = underrun_c;

endmodule

// File: tb/tb_display_buffer_scheduler.sv
// Directed bench for display_buffer_scheduler with an 8x4 active raster (12x6 total).
module tb_display_buffer_scheduler;

  localparam int unsigned ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              CSDisplay;
  logic              wr_valid;
  logic              wr_ready, WE0, WE1, RE0, RE1;
  logic [ADDR_W-1:0] wr_addr, rd_addr, Pxout, Lineout;
  logic              SelBuff1, SelBlank, SyncHB, SyncVB, underrun;
`ifdef DISP_UNDERRUN_CNT_EN
  logic [15:0]       underrun_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  display_buffer_scheduler #(
    .H_ACTIVE (8),
    .H_BLANK  (4),
    .V_ACTIVE (4),
    .V_BLANK  (2),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .CSDisplay      (CSDisplay),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .WE0            (WE0),
    .WE1            (WE1),
    .wr_addr        (wr_addr),
    .RE0            (RE0),
    .RE1            (RE1),
    .rd_addr        (rd_addr),
    .SelBuff1       (SelBuff1),
    .SelBlank       (SelBlank),
    .SyncHB         (SyncHB),
    .SyncVB         (SyncVB),
    .Pxout          (Pxout),
    .Lineout        (Lineout),
`ifdef DISP_UNDERRUN_CNT_EN
    .underrun_count (underrun_count),
`endif
    .underrun       (underrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are then sampled mid-cycle.
  task automatic cyc(input logic csd, input logic wv);
    @(negedge clock);
    CSDisplay = csd;
    wr_valid  = wv;
    #1;
  endtask

  function automatic bit is_act(input int c);
    return ((c % 12) < 8) && (((c / 12) % 6) < 4);
  endfunction

  function automatic bit odd_line(input int c);
    return ((c / 12) % 2) == 1;
  endfunction

  initial begin
    reset     = 1'b1;
    CSDisplay = 1'b0;
    wr_valid  = 1'b0;
    #1 reset  = 1'b0;
    #20;
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_we",       int'(WE0 | WE1), 0);
    chk("rst_re",       int'(RE0 | RE1), 0);
    chk("rst_selblank", int'(SelBlank), 1);
    chk("rst_selbuff1", int'(SelBuff1), 0);
    chk("rst_px",       int'(Pxout), 0);
    chk("rst_ln",       int'(Lineout), 0);
    chk("rst_sync",     int'(SyncHB | SyncVB), 0);
    chk("rst_underrun", int'(underrun), 0);
    @(negedge clock);
    reset = 1'b1;

    // Underrun: writer fills Buf0 only, line 1 finds Buf1 empty.
    cyc(1'b1, 1'b0);
    chk("idle_wr_ready", int'(wr_ready), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1);
      chk("ur_we0",   int'(WE0), 1);
      chk("ur_waddr", int'(wr_addr), i);
    end
    cyc(1'b1, 1'b0);
    chk("ur_prime_px", int'(Pxout), 0);
    for (int c = 0; c < 12; c++) begin
      cyc(1'b1, 1'b0);
      chk("ur_l0_re0", int'(RE0), (c < 8) ? 1 : 0);
    end
    cyc(1'b1, 1'b0);
    chk("ur_pulse",    int'(underrun), 1);
    chk("ur_pulse_re", int'(RE0 | RE1), 0);
    chk("ur_pulse_ln", int'(Lineout), 1);
    for (int c = 13; c < 21; c++) begin
      cyc(1'b1, 1'b1);
      chk("ur_we1",      int'(WE1), 1);
      chk("ur_we1_addr", int'(wr_addr), c - 13);
      chk("ur_blank",    int'(SelBlank), 1);
      chk("ur_no_pulse", int'(underrun), 0);
    end
    for (int c = 21; c < 24; c++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("ur_l2_re1",   int'(RE1), 1);
    chk("ur_l2_raddr", int'(rd_addr), 0);
    chk("ur_l2_ln",    int'(Lineout), 2);
    chk("ur_l2_nopul", int'(underrun), 0);
    cyc(1'b1, 1'b0);
    chk("ur_l2_selb1", int'(SelBuff1), 1);
    chk("ur_l2_blank", int'(SelBlank), 0);
`ifdef DISP_UNDERRUN_CNT_EN
    chk("ur_count", int'(underrun_count), 1);
`endif

    // Drop CSDisplay mid-line: next edge returns to IDLE with everything cleared.
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("off_wr_ready", int'(wr_ready), 0);
    chk("off_px",       int'(Pxout), 0);
    chk("off_ln",       int'(Lineout), 0);
    chk("off_selblank", int'(SelBlank), 1);
    chk("off_selbuff1", int'(SelBuff1), 0);
    chk("off_re",       int'(RE0 | RE1), 0);
`ifdef DISP_UNDERRUN_CNT_EN
    chk("off_count", int'(underrun_count), 0);
`endif

    // Prime with a continuous writer, then steady state across a full frame wrap.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1);
      chk("pr_we0",   int'(WE0), 1);
      chk("pr_waddr", int'(wr_addr), i);
    end
    cyc(1'b1, 1'b1);
    chk("pr_we1",   int'(WE1), 1);
    chk("pr_we0_0", int'(WE0), 0);
    chk("pr_waddr", int'(wr_addr), 0);
    for (int c = 0; c < 76; c++) begin
      cyc(1'b1, 1'b1);
      chk("ss_px",       int'(Pxout), c % 12);
      chk("ss_ln",       int'(Lineout), (c / 12) % 6);
      chk("ss_hb",       int'(SyncHB), ((c % 12) >= 8) ? 1 : 0);
      chk("ss_vb",       int'(SyncVB), (((c / 12) % 6) >= 4) ? 1 : 0);
      chk("ss_re0",      int'(RE0), (is_act(c) && !odd_line(c)) ? 1 : 0);
      chk("ss_re1",      int'(RE1), (is_act(c) && odd_line(c)) ? 1 : 0);
      chk("ss_raddr",    int'(rd_addr), is_act(c) ? (c % 12) : 0);
      chk("ss_selbuff1", int'(SelBuff1), (c > 0 && is_act(c - 1) && odd_line(c - 1)) ? 1 : 0);
      chk("ss_selblank", int'(SelBlank), (c > 0 && is_act(c - 1)) ? 0 : 1);
      chk("ss_underrun", int'(underrun), 0);
      if (c < 7) begin
        chk("ss_we1",   int'(WE1), 1);
        chk("ss_waddr", int'(wr_addr), c + 1);
      end
      if (c == 7) chk("ss_both_full", int'(wr_ready), 0);
      if (c == 8) chk("ss_refill_we0", int'(WE0), 1);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clock);
    chk("ar_pre_px", int'(Pxout), 4);
    #2 reset = 1'b0;
    #1;
    chk("ar_px",       int'(Pxout), 0);
    chk("ar_ln",       int'(Lineout), 0);
    chk("ar_selblank", int'(SelBlank), 1);
    chk("ar_wr_ready", int'(wr_ready), 0);
    chk("ar_we",       int'(WE0 | WE1), 0);
    chk("ar_re",       int'(RE0 | RE1), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
